mc_control_fsm: RTL and testbench

Main sequencing controller for the multi-cycle processor. It owns the 3-bit state register (IF/ID/EX/MEM/WB/HALT) that the fetch, decode, execute and writeback units sample, and it generates per-state datapath controls. It runs the memory request/acknowledge handshake with a timeout watchdog, and maintains cycle and retired-instruction counters.

---
 rtl/mc_control_fsm_if.sv | 10 +
 rtl/mc_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Memory request/acknowledge bus between the sequencing controller and memory.
// Valid/ready: mem_req is held until a single-cycle mem_ack completes the access; mem_we is valid whenever mem_req=1.
interface mc_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic mem_ack;

   modport master (output mem_req, output mem_we, input mem_ack);
   modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor sequencer: IF/ID/EX/MEM/WB/HALT state register, per-state datapath
// controls, memory handshake watchdog, and cycle / retired-instruction counters.
module mc_control_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   mc_control_fsm_if.master mem,
   input  logic [5:0]       i_opcode,
   input  logic [5:0]       i_func,
   input  logic             i_alu_zero,
   output logic [2:0]       o_state,
   output logic             o_ir_write,
   output logic             o_pc_write,
   output logic [1:0]       o_pc_src,
   output logic             o_reg_write,
   output logic             o_reg_dst,
   output logic             o_mem_to_reg,
   output logic [1:0]       o_alu_op,
   output logic             o_illegal,
   output logic             o_bus_error,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [CNT_W-1:0] o_instr_count
);

   typedef enum logic [2:0] {
      S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_t;

   state_t           r_state;
   logic [7:0]       r_wait;
   logic             r_bus_error;
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_instr_count;

   logic w_rfunc_ok, w_rtype, w_addi, w_lw, w_sw, w_beq, w_j, w_halt;
   logic w_waiting, w_timeout, w_retire;

   assign w_rfunc_ok = (i_func == 6'h20) || (i_func == 6'h22) || (i_func == 6'h24) ||
                       (i_func == 6'h25) || (i_func == 6'h2A);
   assign w_rtype = (i_opcode == 6'h00) && w_rfunc_ok;
   assign w_addi  = (i_opcode == 6'h08);
   assign w_lw    = (i_opcode == 6'h23);
   assign w_sw    = (i_opcode == 6'h2B);
   assign w_beq   = (i_opcode == 6'h04);
   assign w_j     = (i_opcode == 6'h02);
   assign w_halt  = (i_opcode == 6'h3F);

   // Ack arriving on the last allowed cycle wins over the timeout.
   assign w_waiting = (r_state == S_IF) || (r_state == S_MEM);
   assign w_timeout = w_waiting && !mem.mem_ack && (r_wait == 8'(TIMEOUT - 1));
   assign w_retire  = ((r_state == S_EX) && (w_beq || w_j || w_halt)) ||
                      ((r_state == S_MEM) && w_sw && mem.mem_ack) ||
                      (r_state == S_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IF;
         r_wait        <= 8'd0;
         r_bus_error   <= 1'b0;
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 1'b1;
         if (w_retire)          r_instr_count <= r_instr_count + 1'b1;
         case (r_state)
            S_IF: begin
               if (mem.mem_ack) begin
                  r_state <= S_ID;
                  r_wait  <= 8'd0;
               end else if (w_timeout) begin
                  r_state     <= S_HALT;
                  r_bus_error <= 1'b1;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_ID: r_state <= S_EX;
            S_EX: begin
               r_wait <= 8'd0;
               if (w_rtype || w_addi)  r_state <= S_WB;
               else if (w_lw || w_sw)  r_state <= S_MEM;
               else if (w_halt)        r_state <= S_HALT;
               else                    r_state <= S_IF;
            end
            S_MEM: begin
               if (mem.mem_ack) begin
                  r_state <= w_sw ? S_IF : S_WB;
                  r_wait  <= 8'd0;
               end else if (w_timeout) begin
                  r_state     <= S_HALT;
                  r_bus_error <= 1'b1;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_WB: begin
               r_state <= S_IF;
               r_wait  <= 8'd0;
            end
            S_HALT: r_state <= S_HALT;
            default: begin
               r_state <= S_IF;
               r_wait  <= 8'd0;
            end
         endcase
      end
   end

   // Controls are decoded from the current state so the datapath sees them in the same cycle.
   always_comb begin
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'b00;
      o_reg_write  = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_alu_op     = 2'b00;
      o_illegal    = 1'b0;
      case (r_state)
         S_IF: begin
            mem.mem_req = 1'b1;
            o_ir_write  = mem.mem_ack;
            o_pc_write  = mem.mem_ack;
         end
         S_EX: begin
            if (w_rtype) begin
               o_alu_op = 2'b10;
            end else if (w_beq) begin
               o_alu_op   = 2'b01;
               o_pc_src   = 2'b01;
               o_pc_write = i_alu_zero;
            end else if (w_j) begin
               o_pc_write = 1'b1;
               o_pc_src   = 2'b10;
            end else if (!(w_addi || w_lw || w_sw || w_halt)) begin
               o_illegal = 1'b1;
            end
         end
         S_MEM: begin
            mem.mem_req = w_lw || w_sw;
            mem.mem_we  = w_sw;
         end
         S_WB: begin
            o_reg_write  = 1'b1;
            o_reg_dst    = w_rtype;
            o_mem_to_reg = w_lw;
         end
         default: ;
      endcase
   end

   assign o_state       = r_state;
   assign o_bus_error   = r_bus_error;
   assign o_cycle_count = r_cycle_count;
   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instructions are expanded into per-cycle stimulus/expectation records
// by an instruction-level model, then replayed against the DUT and checked every cycle.
module tb_mc_control_fsm;
   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int MOD = 16;
   localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       zero;
      logic       ack;
      logic [2:0] st;
      logic       req, we, irw, pcw;
      logic [1:0] pcs;
      logic       rw, rd, m2r;
      logic [1:0] aop;
      logic       ill, berr;
      int         cyc, ins;
      logic       pin;
      int         pin_cyc, pin_ins;
   } rec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [5:0]    opcode = 6'h00;
   logic [5:0]    func = 6'h00;
   logic          alu_zero = 1'b0;
   logic [2:0]    o_state;
   logic          o_ir_write, o_pc_write, o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal, o_bus_error;
   logic [1:0]    o_pc_src, o_alu_op;
   logic [CW-1:0] o_cycle_count, o_instr_count;

   mc_control_fsm_if bus ();

   mc_control_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .mem(bus),
      .i_opcode(opcode), .i_func(func), .i_alu_zero(alu_zero),
      .o_state(o_state), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
      .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg),
      .o_alu_op(o_alu_op), .o_illegal(o_illegal), .o_bus_error(o_bus_error),
      .o_cycle_count(o_cycle_count), .o_instr_count(o_instr_count)
   );

   // scoreboard
   rec_t exp_q[$];
   rec_t cur;
   logic have = 1'b0;
   logic done = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc_idx = 0;

   // instruction-level model state
   int   m_cyc = 0, m_ins = 0;
   logic m_berr = 1'b0;
   logic pin_pend = 1'b0;
   int   pin_c = 0, pin_i = 0;

   logic [5:0] rfn_tab[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
   logic [5:0] ill_tab[3] = '{6'h3E, 6'h01, 6'h10};

   localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_HALT = 6, K_ILL = 7;

   function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? K_R : K_ILL;
         6'h08:   return K_ADDI;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h02:   return K_J;
         6'h3F:   return K_HALT;
         default: return K_ILL;
      endcase
   endfunction

   function automatic rec_t base(input logic [2:0] st);
      rec_t r;
      r = '{default: 0};
      r.op   = 6'($urandom);
      r.fn   = 6'($urandom);
      r.zero = 1'($urandom);
      r.ack  = 1'($urandom);
      r.st   = st;
      return r;
   endfunction

   function automatic void emit(input rec_t r);
      r.berr    = m_berr;
      r.cyc     = m_cyc;
      r.ins     = m_ins;
      r.pin     = pin_pend;
      r.pin_cyc = pin_c;
      r.pin_ins = pin_i;
      pin_pend  = 1'b0;
      exp_q.push_back(r);
      if (r.st != S_HALT && !r.rst) m_cyc = (m_cyc + 1) % MOD;
   endfunction

   function automatic void retire();
      m_ins = (m_ins + 1) % MOD;
   endfunction

   function automatic void pin_next(input int c, input int i);
      pin_pend = 1'b1; pin_c = c; pin_i = i;
   endfunction

   function automatic void pin_last(input int c, input int i);
      rec_t t;
      t = exp_q.pop_back();
      t.pin = 1'b1; t.pin_cyc = c; t.pin_ins = i;
      exp_q.push_back(t);
   endfunction

   function automatic void add_reset();
      rec_t r;
      m_cyc = 0; m_ins = 0; m_berr = 1'b0;
      r = base(S_IF);
      r.rst = 1'b1; r.ack = 1'b0; r.req = 1'b1;
      emit(r);
   endfunction

   function automatic void halt_cycles(input int n);
      for (int k = 0; k < n; k++) emit(base(S_HALT));
   endfunction

   // Waits up to TO cycles for ack; ack on cycle index 'delay' completes, otherwise a bus error.
   function automatic bit wait_phase(input logic [2:0] st, input int delay, input logic [5:0] op,
                                     input logic [5:0] fn, input logic we);
      rec_t r;
      for (int k = 0; k < TO; k++) begin
         r = base(st);
         r.req = 1'b1;
         r.we  = we;
         if (st == S_MEM) begin r.op = op; r.fn = fn; end
         if (k == delay) begin
            r.ack = 1'b1;
            if (st == S_IF) begin r.irw = 1'b1; r.pcw = 1'b1; end
            emit(r);
            return 1'b1;
         end
         r.ack = 1'b0;
         emit(r);
      end
      m_berr = 1'b1;
      return 1'b0;
   endfunction

   function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                                     input int fd, input int md, input bit abort_mem);
      rec_t r;
      int   k;
      k = kind(op, fn);
      if (!wait_phase(S_IF, fd, op, fn, 1'b0)) begin halt_cycles(20); return; end
      emit(base(S_ID));
      r = base(S_EX);
      r.op = op; r.fn = fn; r.zero = zero;
      case (k)
         K_R:        r.aop = 2'b10;
         K_BEQ:      begin r.aop = 2'b01; r.pcs = 2'b01; r.pcw = zero; end
         K_J:        begin r.pcw = 1'b1; r.pcs = 2'b10; end
         K_ILL:      r.ill = 1'b1;
         default:    r.aop = 2'b00;
      endcase
      emit(r);
      if (k == K_BEQ || k == K_J) begin retire(); return; end
      if (k == K_HALT) begin retire(); halt_cycles(20); return; end
      if (k == K_ILL) return;
      if (k == K_LW || k == K_SW) begin
         if (abort_mem) begin
            for (int c = 0; c < 2; c++) begin
               r = base(S_MEM);
               r.op = op; r.fn = fn; r.ack = 1'b0; r.req = 1'b1; r.we = (k == K_SW);
               emit(r);
            end
            return;
         end
         if (!wait_phase(S_MEM, md, op, fn, k == K_SW)) begin halt_cycles(20); return; end
         if (k == K_SW) begin retire(); return; end
      end
      r = base(S_WB);
      r.op = op; r.fn = fn; r.rw = 1'b1; r.rd = (k == K_R); r.m2r = (k == K_LW);
      emit(r);
      retire();
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc_idx, act, exp);
      end
   endtask

   // compare process: sample 2ns after the drive edge, well before the next posedge
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (done) break;
         if (have) begin
            chk("state", 32'(o_state), 32'(cur.st));
            chk("mem_req", 32'(bus.mem_req), 32'(cur.req));
            chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
            chk("ir_write", 32'(o_ir_write), 32'(cur.irw));
            chk("pc_write", 32'(o_pc_write), 32'(cur.pcw));
            chk("pc_src", 32'(o_pc_src), 32'(cur.pcs));
            chk("reg_write", 32'(o_reg_write), 32'(cur.rw));
            chk("reg_dst", 32'(o_reg_dst), 32'(cur.rd));
            chk("mem_to_reg", 32'(o_mem_to_reg), 32'(cur.m2r));
            chk("alu_op", 32'(o_alu_op), 32'(cur.aop));
            chk("illegal", 32'(o_illegal), 32'(cur.ill));
            chk("bus_error", 32'(o_bus_error), 32'(cur.berr));
            chk("cycle_count", 32'(o_cycle_count), 32'(cur.cyc));
            chk("instr_count", 32'(o_instr_count), 32'(cur.ins));
            if (cur.pin) begin
               chk("pin_cycle_count", 32'(o_cycle_count), 32'(cur.pin_cyc));
               chk("pin_instr_count", 32'(o_instr_count), 32'(cur.pin_ins));
            end
         end
         cyc_idx++;
      end
   end

   // driver: build the plan, then replay it one record per cycle
   initial begin
      rec_t r;
      logic [5:0] op, fn;
      bus.mem_ack = 1'b0;

      add_reset(); add_reset(); add_reset();
      add_instr(6'h00, 6'h20, 1'b0, 1, 0, 0);
      pin_next(5, 1);
      add_instr(6'h23, 6'h00, 1'b0, 0, 3, 0);
      add_instr(6'h2B, 6'h00, 1'b0, 0, 1, 0);
      add_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);
      add_instr(6'h04, 6'h00, 1'b0, 0, 0, 0);
      add_instr(6'h3E, 6'h00, 1'b0, 0, 0, 0);
      pin_next(11, 5);
      add_instr(6'h3F, 6'h00, 1'b0, 0, 0, 0);
      pin_last(14, 6);

      add_reset();
      add_instr(6'h02, 6'h00, 1'b0, 4, 0, 0);
      pin_last(4, 0);
      add_reset();
      add_instr(6'h02, 6'h00, 1'b0, 3, 0, 0);
      pin_last(5, 0);
      add_instr(6'h23, 6'h00, 1'b0, 0, 4, 0);

      add_reset();
      for (int n = 0; n < 15; n++) add_instr(6'h02, 6'h00, 1'b0, 0, 0, 0);
      pin_next(13, 15);
      add_instr(6'h23, 6'h00, 1'b0, 0, 0, 1);
      add_reset();
      pin_last(0, 0);
      for (int n = 0; n < 16; n++) add_instr(6'h02, 6'h00, 1'b0, 0, 0, 0);
      pin_next(0, 0);

      for (int n = 0; n < 60; n++) begin
         fn = 6'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 9: begin op = 6'h00; fn = rfn_tab[$urandom_range(0, 4)]; end
            2:       op = 6'h08;
            3:       op = 6'h23;
            4:       op = 6'h2B;
            5:       op = 6'h04;
            6:       op = 6'h02;
            7:       begin op = 6'h00; fn = 6'h21; end
            default: op = ill_tab[$urandom_range(0, 2)];
         endcase
         add_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         r = exp_q[i];
         rst_n       = ~r.rst;
         opcode      = r.op;
         func        = r.fn;
         alu_zero    = r.zero;
         bus.mem_ack = r.ack;
         cur  = r;
         have = 1'b1;
      end
      @(negedge clk);
      done = 1'b1;
      #5;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
